// File: rtl/hex_scroll_display.sv
// N-digit 7-segment engine: one-deep shadow buffer committed on a display tick,
// static/blink/rotate-scroll modes with leading-zero blanking, active-low segments.
module hex_scroll_display #(
  parameter int NUM_DIGITS = 8,
  parameter int TICK_DIV   = 25000000
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  input  logic [1:0]              mode,
  input  logic                    blank_lz,
  output logic [7*NUM_DIGITS-1:0] hex_export,
  output logic                    scroll_wrap
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int OW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);
  localparam logic [OW-1:0] OFS_TOP   = OW'(NUM_DIGITS - 1);
  localparam logic [1:0] MODE_BLINK  = 2'b01;
  localparam logic [1:0] MODE_SCROLL = 2'b10;

  logic [PW-1:0]           presc;
  logic                    tick;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [4*NUM_DIGITS-1:0] disp_reg;
  logic                    shadow_full;
  logic [OW-1:0]           offset;
  logic                    blink_phase;
  logic [1:0]              mode_q;
  logic                    commit;
  logic                    mode_chg;
  logic [7*NUM_DIGITS-1:0] seg_next;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'h0: seg_decode = 7'h40;
      4'h1: seg_decode = 7'h79;
      4'h2: seg_decode = 7'h24;
      4'h3: seg_decode = 7'h30;
      4'h4: seg_decode = 7'h19;
      4'h5: seg_decode = 7'h12;
      4'h6: seg_decode = 7'h02;
      4'h7: seg_decode = 7'h78;
      4'h8: seg_decode = 7'h00;
      4'h9: seg_decode = 7'h10;
      4'hA: seg_decode = 7'h08;
      4'hB: seg_decode = 7'h03;
      4'hC: seg_decode = 7'h46;
      4'hD: seg_decode = 7'h21;
      4'hE: seg_decode = 7'h06;
      default: seg_decode = 7'h0E;
    endcase
  endfunction

  assign tick     = (presc == PRESC_TOP);
  assign wr_ready = ~shadow_full;
  assign commit   = tick && shadow_full;
  assign mode_chg = (mode != mode_q);

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      shadow      <= '0;
      shadow_full <= 1'b0;
      disp_reg    <= '0;
      offset      <= '0;
      blink_phase <= 1'b0;
      mode_q      <= 2'b00;
      scroll_wrap <= 1'b0;
    end else begin
      mode_q      <= mode;
      scroll_wrap <= 1'b0;
      // A write can never coincide with a commit: commit needs a full shadow.
      if (wr_valid && !shadow_full) begin
        shadow      <= wr_data;
        shadow_full <= 1'b1;
      end else if (commit) begin
        disp_reg    <= shadow;
        shadow_full <= 1'b0;
      end
      if (commit || mode_chg) begin
        offset      <= '0;
        blink_phase <= 1'b0;
      end else if (tick) begin
        if (mode_q == MODE_BLINK) blink_phase <= ~blink_phase;
        if (mode_q == MODE_SCROLL) begin
          if (offset == OFS_TOP) begin
            offset      <= '0;
            scroll_wrap <= 1'b1;
          end else begin
            offset <= offset + OW'(1);
          end
        end
      end
    end
  end

  always_comb begin
    int         src;
    logic [3:0] nib;
    logic [6:0] seg;
    logic       lz;
    seg_next = '0;
    src      = 0;
    nib      = 4'h0;
    seg      = 7'h7F;
    lz       = blank_lz && (mode_q != MODE_SCROLL);
    // Walk from the most significant digit so the zero run is detected in order.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (mode_q == MODE_SCROLL) begin
        src = i + NUM_DIGITS - int'(offset);
        if (src >= NUM_DIGITS) src = src - NUM_DIGITS;
      end else begin
        src = i;
      end
      nib = disp_reg[4*src +: 4];
      seg = seg_decode(nib);
      if (lz && (i != 0) && (nib == 4'h0)) begin
        seg = 7'h7F;
      end else begin
        lz = 1'b0;
      end
      if ((mode_q == MODE_BLINK) && blink_phase) seg = 7'h7F;
      seg_next[7*i +: 7] = seg;
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      hex_export <= '1;
    end else begin
      hex_export <= seg_next;
    end
  end

endmodule

// File: tb/tb_hex_scroll_display.sv
// Directed bench for hex_scroll_display with 8 digits and a 4-cycle tick.
module tb_hex_scroll_display;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic [1:0]  mode;
  logic        blank_lz;
  logic [55:0] hex_export;
  logic        scroll_wrap;

  int checks = 0;
  int errors = 0;

  localparam logic [55:0] ALL_ONES  = {8{7'h7F}};
  localparam logic [55:0] ALL_ZEROS = {8{7'h40}};

  hex_scroll_display #(.NUM_DIGITS(8), .TICK_DIV(4)) dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .mode        (mode),
    .blank_lz    (blank_lz),
    .hex_export  (hex_export),
    .scroll_wrap (scroll_wrap)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic check(input string tag, input logic [55:0] obs, input logic [55:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_clk);
    #1;
  endtask

  // Present d, then hold a different value on the port while the shadow is full;
  // returns just after the commit edge (wr_ready observed high again).
  task automatic write_commit(input string tag, input logic [31:0] d, input logic [31:0] junk);
    int n;
    wr_valid = 1'b1;
    wr_data  = d;
    step(1);
    check({tag, "_ready_low"}, 56'(wr_ready), 56'(1'b0));
    wr_data = junk;
    n = 0;
    while (!wr_ready && n < 20) begin
      step(1);
      n++;
    end
    wr_valid = 1'b0;
    check({tag, "_commit"}, 56'(wr_ready), 56'(1'b1));
  endtask

  function automatic logic [55:0] one_at(input int d);
    logic [55:0] r;
    r = ALL_ZEROS;
    r[7*d +: 7] = 7'h79;
    return r;
  endfunction

  initial begin
    int wraps;
    reset_reset = 1'b1;
    wr_valid    = 1'b0;
    wr_data     = '0;
    mode        = 2'b00;
    blank_lz    = 1'b0;

    step(2);
    check("reset_hex", hex_export, ALL_ONES);
    check("reset_wrap", 56'(scroll_wrap), 56'(1'b0));
    check("reset_ready", 56'(wr_ready), 56'(1'b1));
    reset_reset = 1'b0;
    step(1);
    check("idle_hex", hex_export, ALL_ZEROS);
    check("idle_ready", 56'(wr_ready), 56'(1'b1));

    write_commit("static", 32'h0000_12AF, 32'hDEAD_BEEF);
    step(1);
    check("static_hex", hex_export,
          {7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h24, 7'h08, 7'h0E});

    blank_lz = 1'b1;
    step(1);
    check("blank_hex", hex_export,
          {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h08, 7'h0E});
    write_commit("zero", 32'h0, 32'h1111_1111);
    step(1);
    check("blank_zero_hex", hex_export, {{7{7'h7F}}, 7'h40});

    blank_lz = 1'b0;
    mode     = 2'b01;
    write_commit("blink", 32'h8, 32'h3);
    step(1);
    check("blink_on", hex_export, {{7{7'h40}}, 7'h00});
    step(4);
    check("blink_off", hex_export, ALL_ONES);
    step(1);
    mode = 2'b00;
    step(2);
    check("blink_to_static", hex_export, {{7{7'h40}}, 7'h00});
    mode = 2'b01;
    step(2);
    check("blink_phase_reset", hex_export, {{7{7'h40}}, 7'h00});
    step(3);
    check("blink_off_again", hex_export, ALL_ONES);

    mode = 2'b10;
    write_commit("scroll", 32'h1, 32'h5);
    step(1);
    check("scroll_d0", hex_export, one_at(0));
    wraps = 0;
    for (int c = 2; c <= 34; c++) begin
      step(1);
      if (scroll_wrap) wraps++;
      if (c == 32) check("scroll_wrap_at_wrap", 56'(scroll_wrap), 56'(1'b1));
      if ((c - 1) % 4 == 0) check($sformatf("scroll_step%0d", (c - 1) / 4), hex_export,
                                  one_at(((c - 1) / 4) % 8));
    end
    check("scroll_wrap_count", 56'(wraps), 56'(1));

    wr_valid = 1'b1;
    wr_data  = 32'h7;
    step(1);
    wr_valid = 1'b0;
    check("pending_ready_low", 56'(wr_ready), 56'(1'b0));
    reset_reset = 1'b1;
    #1;
    check("midreset_hex", hex_export, ALL_ONES);
    check("midreset_wrap", 56'(scroll_wrap), 56'(1'b0));
    step(2);
    reset_reset = 1'b0;
    step(1);
    check("postreset_ready", 56'(wr_ready), 56'(1'b1));
    check("postreset_hex", hex_export, ALL_ZEROS);
    for (int k = 0; k < 3; k++) begin
      step(4);
      check($sformatf("no_stale_%0d", k), hex_export, ALL_ZEROS);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_scroll_display.md
Name: hex_scroll_display

Overview:
Parametrised multi-digit 7-segment display engine, generalising the fixed 8-digit hex outputs of the current system to N digits. Takes a packed hex value via a valid/ready write port into a one-deep shadow buffer, then commits it on a display tick. Supports static, blink and rotate-scroll modes plus leading-zero blanking. Drives active-low segment buses for the board HEX displays.

Parameters:
NUM_DIGITS, 8, number of 7-seg digits driven (range 2..16)
TICK_DIV, 25000000, clk_clk cycles per display tick (>= 2); sets blink/scroll rate and commit cadence

Ports:
clk_clk  input  1  system clock
reset_reset  input  1  asynchronous, active-high reset
wr_valid  input  1  write request
wr_ready  output  1  shadow buffer empty, write accepted when wr_valid && wr_ready
wr_data  input  4*NUM_DIGITS  packed nibbles, nibble i -> digit i (digit 0 = rightmost)
mode  input  2  00 static, 01 blink, 10 scroll, 11 treated as static
blank_lz  input  1  blank leading zero digits (static/blink only)
hex_export  output  7*NUM_DIGITS  segments, bits [7i+6:7i] = digit i, active-low, bit 0 = seg a ... bit 6 = seg g
scroll_wrap  output  1  one-cycle pulse when scroll offset wraps to 0

Behaviour:
- Reset (async, immediate): prescaler=0, tick=0, disp_reg=0, shadow empty, wr_ready=1, offset=0, blink_phase=0, mode_q=00, hex_export all ones (blank), scroll_wrap=0.
- Prescaler: counts 0..TICK_DIV-1, wraps; tick pulses high for one cycle when count==TICK_DIV-1.
- Write: on wr_valid && wr_ready: shadow<=wr_data, shadow_full<=1; wr_ready registered = ~shadow_full (goes 0 the cycle after accept). wr_valid with wr_ready=0 ignored; no data loss tracking.
- Commit: on tick with shadow_full: disp_reg<=shadow, shadow_full<=0, offset<=0, blink_phase<=0; wr_ready returns 1 next cycle. Write in commit cycle impossible (wr_ready=0).
- Mode change: mode registered into mode_q each cycle; when mode != mode_q, offset<=0 and blink_phase<=0 (overrides tick advance that cycle).
- Blink: on tick (no commit), blink_phase toggles; phase 1 -> all digits 7'h7F.
- Scroll: on tick (no commit), offset<=(offset+1) mod NUM_DIGITS; digit i shows nibble (i - offset) mod NUM_DIGITS (rotates toward higher digits). scroll_wrap=1 in the cycle after offset returns to 0 via increment (not via commit/mode reset).
- Offset and blink_phase hold when not in their mode.
- Blanking: when blank_lz=1 and mode in {static, blink}, contiguous zero nibbles from digit NUM_DIGITS-1 downward show 7'h7F; digit 0 never blanked. Ignored in scroll.
- Decode (active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
- Latency: hex_export registered; reflects disp_reg/offset/phase/mode/blank_lz state one cycle after they change.
- Reset mid-operation: pending shadow discarded, display blanks, scroll restarts at offset 0.

Test Plan:
- Reset then idle, NUM_DIGITS=8, TICK_DIV=4: hex_export all ones during reset; one cycle after release every digit = 7'h40, wr_ready=1.
- Write 0x0000_12AF static, blank_lz=0: wr_ready low until next tick, then digits 0..3 = 0E,08,24,79, digits 4..7 = 40; wr_ready back to 1 one cycle after commit.
- Same value with blank_lz=1: digits 4..7 = 7F, digits 0..3 unchanged; value 0 with blank_lz=1 -> only digit 0 = 40.
- Blink, value 0x8: digit 0 alternates 00 / 7F every 4 cycles; mode switch to static mid-phase-1 -> display restored within 2 cycles, phase=0.
- Scroll, value 0x0000_0001: digit 1,2,...,7,0 shows 79 on successive ticks; scroll_wrap pulses once after 8th tick; second write during shadow_full with wr_ready=0 ignored.
- Assert reset mid-scroll with shadow full: outputs blank immediately, after release wr_ready=1, display 0, offset 0, earlier shadow value never appears.
